word_byte_serializer: RTL
=========================

// Module: word_byte_serializer
// PURPOSE
//   Downstream stage of the 32-bit increment pipeline: consumes its valid/ready word stream and
//   emits it as an 8-bit valid/ready byte stream for the narrow host/transmit path.
//   Groups FRAME_WORDS words into a frame, flags the frame's last byte and counts frames.
//   Sustains 1 byte/cycle: back-to-back words with no bubble while o_rdy stays high.
// PARAMETERS
//   MSB_FIRST    1  1: byte order i_data[31:24] first; 0: i_data[7:0] first
//   FRAME_WORDS  4  words per frame, legal range 1..256
// PORTS
//   clk          in   1   clock; all logic on rising edge
//   rst_n        in   1   asynchronous reset, active-low
//   i_rdy        out  1   word accept; a transfer is i_val && i_rdy at the clk edge
//   i_val        in   1   upstream word valid
//   i_data       in   32  upstream word
//   o_rdy        in   1   downstream byte accept
//   o_val        out  1   byte valid
//   o_data       out  8   byte
//   o_last       out  1   qualifies o_data as the final byte of the current frame
//   o_frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset (rst_n low, async): state IDLE; o_val=0, o_data=0, o_last=0, o_frame_cnt=0.
//     Byte index, word-in-frame count and checksum cleared. i_rdy forced 0 while rst_n low.
//   Reset mid-frame discards the held word, the partial frame and the checksum. The next
//     accepted word starts a new frame.
//   State machine:
//     IDLE: o_val=0, i_rdy=1; word accepted -> SEND, idx=0
//     SEND: o_val=1, o_data=byte[idx]; byte accepted (o_val&&o_rdy) -> idx+1
//     CSUM: feature only; o_val=1, o_data=checksum, o_last=1
//   Leaving SEND when idx==3 and the byte is accepted:
//     - frame not complete: if i_val, load the new word, stay in SEND, idx=0; else -> IDLE
//     - frame complete: -> CSUM if feature built in; otherwise -> SEND with a new word, or -> IDLE
//   i_rdy = IDLE, or (SEND && idx==3 && o_rdy && no CSUM due). This is a combinational
//     o_rdy->i_rdy path, and it is the only one.
//   Output stability: o_val, o_data and o_last are held unchanged while o_val && !o_rdy.
//   Latency: first byte valid 1 cycle after word acceptance. The word register holds 1 word.
//   Frame count wcnt runs 0..FRAME_WORDS-1 and advances on byte 3 acceptance. It wraps to 0 at
//     frame completion, which also increments o_frame_cnt.
//   FRAME_WORDS=1: every word is one frame. o_last rule applies unchanged.
//   o_rdy high with o_val low: ignored, no state change.
//   o_last, feature absent: asserted on byte 3 of word FRAME_WORDS-1.
// CONFIGURATION
//   WBS_CHECKSUM_EN defined:
//     - after the last data byte of each frame, a CSUM byte is emitted
//     - CSUM byte = 8-bit sum mod 256 of all 4*FRAME_WORDS data bytes of the frame
//     - o_last marks the CSUM byte only, not the data bytes
//     - i_rdy=0 throughout CSUM
//     - o_frame_cnt increments, and the checksum clears, when the CSUM byte is accepted
//   WBS_CHECKSUM_EN undefined: no CSUM state, no adder; frames carry 4*FRAME_WORDS bytes.
// TESTING
//   1 MSB_FIRST=1, o_rdy=1, word 0x11223344 -> o_data 11,22,33,44 on 4 consecutive cycles, then o_val=0
//   2 MSB_FIRST=0, words 0xA1B2C3D4,0x0A0B0C0D back-to-back, o_rdy=1 ->
//       D4,C3,B2,A1,0D,0C,0B,0A on 8 consecutive cycles; i_rdy=1 only in the cycle byte A1 is accepted
//   3 o_rdy low for 5 cycles during byte 1 of 0xDEADBEEF -> o_data holds 0xAD and o_val holds 1;
//       no byte is lost or duplicated
//   4 FRAME_WORDS=4, no checksum, 8 words streamed -> o_last high on bytes 16 and 32 only; o_frame_cnt=2
//   5 WBS_CHECKSUM_EN, FRAME_WORDS=4, 4 words of 0x01020304 -> 16 data bytes, then CSUM byte 0x28
//       with o_last=1; i_rdy=0 during CSUM
//   6 rst_n pulsed low after byte 2 of word 2 -> outputs zero immediately; next word's first byte
//       starts a new frame; o_frame_cnt=0

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
//   Turns a 32-bit valid/ready word stream into an 8-bit valid/ready byte
//   stream at one byte per cycle.
//   Words are grouped into frames of FRAME_WORDS words. o_last marks the final
//   byte of each frame. o_frame_cnt counts completed frames.
//
//   Optional feature: WBS_CHECKSUM_EN. When it is defined, each frame is
//   followed by one extra byte, which is the mod-256 sum of the frame's data
//   bytes. In that case o_last marks only this checksum byte.
//
// Parameters
//   MSB_FIRST    1: i_data[31:24] goes out first; 0: i_data[7:0] goes out first
//   FRAME_WORDS  number of words per frame (1..256)
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   i_val, i_rdy, i_data      upstream word handshake and data
//   o_val, o_rdy, o_data      downstream byte handshake and data
//   o_last                    final byte of the current frame
//   o_frame_cnt               number of completed frames; wraps at 16 bits
module word_byte_serializer #(
  parameter int MSB_FIRST   = 1,
  parameter int FRAME_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i_rdy,
  input  logic        i_val,
  input  logic [31:0] i_data,
  input  logic        o_rdy,
  output logic        o_val,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic [15:0] o_frame_cnt
);

  localparam logic [7:0] LAST_W = 8'(FRAME_WORDS - 1);

`ifdef WBS_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] word;
  logic [1:0]  idx;
  logic [7:0]  wcnt;
  logic [15:0] frame_cnt;
  logic [1:0]  sh;
  logic [7:0]  cur_byte;
  logic        last_word, byte_acc, word_end, load, csum_due;

  assign last_word = (wcnt == LAST_W);
  assign byte_acc  = (state == SEND) && o_rdy;
  assign word_end  = byte_acc && (idx == 2'd3);

`ifdef WBS_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_acc;
  assign csum_acc = (state == CSUM) && o_rdy;
  // The frame's final word is followed by the checksum byte, not by a new word.
  assign csum_due = last_word;
`else
  assign csum_due = 1'b0;
`endif

  // This is the only combinational path from o_rdy to i_rdy. It lets a new
  // word be loaded in the same cycle that the previous word's last byte
  // leaves, so there is no bubble between words.
  assign i_rdy = rst_n && ((state == IDLE) ||
                 ((state == SEND) && (idx == 2'd3) && o_rdy && !csum_due));
  assign load  = i_val && i_rdy;

  // Select the outgoing byte from the held word.
  always_comb begin
    sh       = (MSB_FIRST != 0) ? (2'd3 - idx) : idx;
    cur_byte = word[{sh, 3'b000} +: 8];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = SEND;
      SEND: begin
        if (word_end) begin
`ifdef WBS_CHECKSUM_EN
          if (last_word) state_nxt = CSUM;
          else
`endif
          state_nxt = load ? SEND : IDLE;
        end
      end
`ifdef WBS_CHECKSUM_EN
      CSUM: if (o_rdy) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // The outputs are decoded from registered state only. While the consumer
  // stalls, that state does not change, so the outputs stay stable.
  always_comb begin
    o_val  = 1'b0;
    o_data = 8'd0;
    o_last = 1'b0;
    case (state)
      SEND: begin
        o_val  = 1'b1;
        o_data = cur_byte;
`ifndef WBS_CHECKSUM_EN
        o_last = (idx == 2'd3) && last_word;
`endif
      end
`ifdef WBS_CHECKSUM_EN
      CSUM: begin
        o_val  = 1'b1;
        o_data = csum;
        o_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      wcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        word <= i_data;
        idx  <= 2'd0;
      end else if (byte_acc) begin
        idx  <= idx + 2'd1;
      end
      if (word_end) wcnt <= last_word ? 8'd0 : wcnt + 8'd1;
`ifdef WBS_CHECKSUM_EN
      if (csum_acc) frame_cnt <= frame_cnt + 16'd1;
`else
      if (word_end && last_word) frame_cnt <= frame_cnt + 16'd1;
`endif
    end
  end

`ifdef WBS_CHECKSUM_EN
  // Accumulate every accepted data byte. The sum is cleared once the
  // checksum byte has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum <= '0;
    else if (byte_acc) csum <= csum + cur_byte;
    else if (csum_acc) csum <= '0;
  end
`endif

  assign o_frame_cnt = frame_cnt;

endmodule
